chnl_host_port: RTL and testbench

Host-side endpoint of one RIFFA channel: the counterpart of a user channel core. It originates RX transactions (CHNL_RX* toward the user core) from a host-side word stream, and terminates TX transactions (CHNL_TX* from the user core) into a host-side word stream. It is instantiated in simulation harnesses and in on-chip self-test builds to drive user cores such as the loopback tester without the PCIe engine.

---
 rtl/chnl_host_port.sv | 206 ++++++++++++++++++++
 tb/tb_chnl_host_port.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chnl_host_port.sv
// Host-side endpoint of one RIFFA channel: originates RX transactions toward a user core from a
// host word stream and terminates the user core's TX transactions into a host word stream.
module chnl_host_port #(
    parameter int C_PCI_DATA_WIDTH = 32
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        START,
    input  logic [31:0]                 START_LEN,
    input  logic [30:0]                 START_OFF,
    input  logic                        START_LAST,
    input  logic [C_PCI_DATA_WIDTH-1:0] HWR_DATA,
    input  logic                        HWR_VALID,
    output logic                        HWR_READY,
    output logic [C_PCI_DATA_WIDTH-1:0] HRD_DATA,
    output logic                        HRD_VALID,
    input  logic                        HRD_READY,
    output logic                        RX_BUSY,
    output logic                        RX_DONE,
    output logic                        TX_DONE,
    output logic [31:0]                 TX_LEN_Q,
    output logic                        CHNL_RX,
    output logic                        CHNL_RX_LAST,
    output logic [31:0]                 CHNL_RX_LEN,
    output logic [30:0]                 CHNL_RX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    output logic                        CHNL_RX_DATA_VALID,
    input  logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_DATA_REN,
    input  logic                        CHNL_TX,
    input  logic                        CHNL_TX_LAST,
    input  logic [31:0]                 CHNL_TX_LEN,
    input  logic [30:0]                 CHNL_TX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    input  logic                        CHNL_TX_DATA_VALID,
    output logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_DATA_REN
);
    localparam int W = C_PCI_DATA_WIDTH / 32;
    localparam logic [32:0] W_INC = 33'(W);

    typedef enum logic [1:0] {RxIdle, RxReq, RxData, RxDone} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxAck, TxData, TxDone} tx_state_e;

    // ---------------- RX: host stream -> user core ----------------
    rx_state_e                   r_rx_st;
    logic [31:0]                 r_rx_len;
    logic [31:0]                 r_rx_cnt;
    logic [31:0]                 r_rx_ld;
    logic [30:0]                 r_rx_off;
    logic                        r_rx_last;
    logic                        r_rx_full;
    logic [C_PCI_DATA_WIDTH-1:0] r_rx_data;

    logic [32:0] w_rx_cnt_nxt;
    logic [32:0] w_rx_ld_nxt;
    logic        w_rx_ld_more;
    logic        w_rx_xfer;
    logic        w_hwr_ready;
    logic        w_hwr_fire;

    assign w_rx_cnt_nxt = {1'b0, r_rx_cnt} + W_INC;
    assign w_rx_ld_nxt  = {1'b0, r_rx_ld} + W_INC;
    // r_rx_ld counts words loaded, so the host is stalled once the final beat is in the register
    assign w_rx_ld_more = r_rx_ld < r_rx_len;
    assign w_rx_xfer    = r_rx_full & CHNL_RX_DATA_REN;
    assign w_hwr_ready  = (r_rx_st == RxData) & w_rx_ld_more & (~r_rx_full | CHNL_RX_DATA_REN);
    assign w_hwr_fire   = HWR_VALID & w_hwr_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_st   <= RxIdle;
            r_rx_len  <= '0;
            r_rx_cnt  <= '0;
            r_rx_ld   <= '0;
            r_rx_off  <= '0;
            r_rx_last <= 1'b0;
            r_rx_full <= 1'b0;
            r_rx_data <= '0;
        end else begin
            case (r_rx_st)
                RxIdle: begin
                    if (START) begin
                        r_rx_len  <= START_LEN;
                        r_rx_off  <= START_OFF;
                        r_rx_last <= START_LAST;
                        r_rx_cnt  <= '0;
                        r_rx_ld   <= '0;
                        r_rx_st   <= RxReq;
                    end
                end
                RxReq: begin
                    if (CHNL_RX_ACK) begin
                        r_rx_st <= (r_rx_len == '0) ? RxDone : RxData;
                    end
                end
                RxData: begin
                    if (w_hwr_fire) begin
                        r_rx_data <= HWR_DATA;
                        r_rx_ld   <= w_rx_ld_nxt[32] ? '1 : w_rx_ld_nxt[31:0];
                        r_rx_full <= 1'b1;
                    end else if (w_rx_xfer) begin
                        r_rx_full <= 1'b0;
                    end
                    if (w_rx_xfer) begin
                        r_rx_cnt <= w_rx_cnt_nxt[31:0];
                        if (w_rx_cnt_nxt >= {1'b0, r_rx_len}) begin
                            r_rx_st <= RxDone;
                        end
                    end
                end
                RxDone: r_rx_st <= RxIdle;
                default: r_rx_st <= RxIdle;
            endcase
        end
    end

    assign HWR_READY          = w_hwr_ready;
    assign RX_BUSY            = (r_rx_st != RxIdle);
    assign RX_DONE            = (r_rx_st == RxDone);
    assign CHNL_RX            = (r_rx_st == RxReq) | (r_rx_st == RxData);
    assign CHNL_RX_LEN        = r_rx_len;
    assign CHNL_RX_OFF        = r_rx_off;
    assign CHNL_RX_LAST       = r_rx_last;
    assign CHNL_RX_DATA       = r_rx_data;
    assign CHNL_RX_DATA_VALID = r_rx_full;

    // ---------------- TX: user core -> host stream ----------------
    tx_state_e                   r_tx_st;
    logic [31:0]                 r_tx_len;
    logic [31:0]                 r_tx_cnt;
    logic                        r_tx_seen;
    logic                        r_hrd_valid;
    logic [C_PCI_DATA_WIDTH-1:0] r_hrd_data;

    logic [32:0] w_tx_cnt_nxt;
    logic        w_tx_ren;
    logic        w_tx_acc;
    logic        w_hrd_fire;
    logic        w_tx_done;

    assign w_tx_cnt_nxt = {1'b0, r_tx_cnt} + W_INC;
    assign w_tx_ren     = (r_tx_st == TxData) & (~r_hrd_valid | HRD_READY);
    assign w_tx_acc     = CHNL_TX_DATA_VALID & w_tx_ren;
    assign w_hrd_fire   = r_hrd_valid & HRD_READY;
    // Pulse only after the last beat has left for the host, and only once per request
    assign w_tx_done    = (r_tx_st == TxDone) & ~r_hrd_valid & ~r_tx_seen;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx_st     <= TxIdle;
            r_tx_len    <= '0;
            r_tx_cnt    <= '0;
            r_tx_seen   <= 1'b0;
            r_hrd_valid <= 1'b0;
            r_hrd_data  <= '0;
        end else begin
            if (w_tx_acc) begin
                r_hrd_data  <= CHNL_TX_DATA;
                r_hrd_valid <= 1'b1;
            end else if (w_hrd_fire) begin
                r_hrd_valid <= 1'b0;
            end
            case (r_tx_st)
                TxIdle: begin
                    if (CHNL_TX) begin
                        r_tx_len <= CHNL_TX_LEN;
                        r_tx_cnt <= '0;
                        r_tx_st  <= TxAck;
                    end
                end
                TxAck: r_tx_st <= (r_tx_len == '0) ? TxDone : TxData;
                TxData: begin
                    if (w_tx_acc) begin
                        r_tx_cnt <= w_tx_cnt_nxt[31:0];
                        if (w_tx_cnt_nxt >= {1'b0, r_tx_len}) begin
                            r_tx_st <= TxDone;
                        end
                    end
                end
                TxDone: begin
                    if (w_tx_done) begin
                        r_tx_seen <= 1'b1;
                    end
                    if ((r_tx_seen | w_tx_done) & ~CHNL_TX) begin
                        r_tx_seen <= 1'b0;
                        r_tx_st   <= TxIdle;
                    end
                end
                default: r_tx_st <= TxIdle;
            endcase
        end
    end

    assign HRD_DATA         = r_hrd_data;
    assign HRD_VALID        = r_hrd_valid;
    assign TX_DONE          = w_tx_done;
    assign TX_LEN_Q         = r_tx_len;
    assign CHNL_TX_ACK      = (r_tx_st == TxAck);
    assign CHNL_TX_DATA_REN = w_tx_ren;

    // Offset and last flag of TX requests carry no meaning for the host sink
    logic w_unused;
    assign w_unused = ^{CHNL_TX_LAST, CHNL_TX_OFF};

endmodule

// File: tb/tb_chnl_host_port.sv
// Self-checking bench for chnl_host_port (64-bit channel, two words per beat): the bench plays
// both the host streams and the user core, and checks against a word-level transaction model.
module tb_chnl_host_port;
    localparam int DW = 64;
    localparam int W  = DW / 32;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [31:0]   START_LEN = '0;
    logic [30:0]   START_OFF = '0;
    logic          START_LAST = 1'b0;
    logic [DW-1:0] HWR_DATA = '0;
    logic          HWR_VALID = 1'b0;
    logic          HWR_READY;
    logic [DW-1:0] HRD_DATA;
    logic          HRD_VALID;
    logic          HRD_READY = 1'b0;
    logic          RX_BUSY, RX_DONE, TX_DONE;
    logic [31:0]   TX_LEN_Q;
    logic          CHNL_RX, CHNL_RX_LAST;
    logic [31:0]   CHNL_RX_LEN;
    logic [30:0]   CHNL_RX_OFF;
    logic [DW-1:0] CHNL_RX_DATA;
    logic          CHNL_RX_DATA_VALID;
    logic          CHNL_RX_ACK = 1'b0;
    logic          CHNL_RX_DATA_REN = 1'b0;
    logic          CHNL_TX = 1'b0;
    logic          CHNL_TX_LAST = 1'b0;
    logic [31:0]   CHNL_TX_LEN = '0;
    logic [30:0]   CHNL_TX_OFF = '0;
    logic [DW-1:0] CHNL_TX_DATA = '0;
    logic          CHNL_TX_DATA_VALID = 1'b0;
    logic          CHNL_TX_ACK, CHNL_TX_DATA_REN;

    chnl_host_port #(.C_PCI_DATA_WIDTH(DW)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .START(START), .START_LEN(START_LEN), .START_OFF(START_OFF), .START_LAST(START_LAST),
        .HWR_DATA(HWR_DATA), .HWR_VALID(HWR_VALID), .HWR_READY(HWR_READY),
        .HRD_DATA(HRD_DATA), .HRD_VALID(HRD_VALID), .HRD_READY(HRD_READY),
        .RX_BUSY(RX_BUSY), .RX_DONE(RX_DONE), .TX_DONE(TX_DONE), .TX_LEN_Q(TX_LEN_Q),
        .CHNL_RX(CHNL_RX), .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN),
        .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
        .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_ACK(CHNL_RX_ACK),
        .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
        .CHNL_TX(CHNL_TX), .CHNL_TX_LAST(CHNL_TX_LAST), .CHNL_TX_LEN(CHNL_TX_LEN),
        .CHNL_TX_OFF(CHNL_TX_OFF), .CHNL_TX_DATA(CHNL_TX_DATA),
        .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID), .CHNL_TX_ACK(CHNL_TX_ACK),
        .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment knobs and observations
    int  ren_mode = 0;   // 0: always, 1: toggle, 2: random
    int  hwr_pct  = 100;
    int  txv_pct  = 100;
    bit  ack_en   = 1'b1;
    bit  ren_tog  = 1'b0;
    bit  loopback = 1'b0;
    bit  stall_arm = 1'b0;
    int  hrd_stall = 0;
    int  step_cnt = 0;
    int  rx_done_cnt, tx_done_cnt, tx_ack_cnt, rx_hi, rx_unstable, ren_viol, stall_full;
    int  rx_rise_step, tx_ack_step;
    bit  rx_seen;
    logic [63:0] rx_hdr;
    logic [DW-1:0] hwr_q[$];
    logic [DW-1:0] sent[$];
    logic [DW-1:0] rx_got[$];
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] tx_sent[$];
    logic [DW-1:0] hrd_got[$];

    task automatic clear_obs();
        rx_done_cnt = 0; tx_done_cnt = 0; tx_ack_cnt = 0; rx_hi = 0; rx_unstable = 0;
        ren_viol = 0; stall_full = 0; rx_rise_step = -1; tx_ack_step = -1; rx_seen = 1'b0;
        rx_hdr = '0; hwr_q.delete(); sent.delete(); rx_got.delete(); tx_q.delete();
        tx_sent.delete(); hrd_got.delete(); hrd_stall = 0; stall_arm = 1'b0; loopback = 1'b0;
    endtask

    task automatic load_hwr(input int n);
        logic [DW-1:0] b;
        for (int i = 0; i < n; i++) begin
            b = {$urandom, $urandom};
            hwr_q.push_back(b);
            sent.push_back(b);
        end
    endtask

    task automatic load_tx(input int n);
        logic [DW-1:0] b;
        for (int i = 0; i < n; i++) begin
            b = {$urandom, $urandom};
            tx_q.push_back(b);
            tx_sent.push_back(b);
        end
    endtask

    // One clock: drive at the falling edge, observe handshakes just after
    task automatic step();
        @(negedge CLK);
        START = 1'b0;
        CHNL_RX_ACK = CHNL_RX & ack_en;
        case (ren_mode)
            0: CHNL_RX_DATA_REN = 1'b1;
            1: begin ren_tog = ~ren_tog; CHNL_RX_DATA_REN = ren_tog; end
            default: CHNL_RX_DATA_REN = 1'($urandom_range(0, 1));
        endcase
        HWR_VALID = (hwr_q.size() > 0) && (int'($urandom_range(0, 99)) < hwr_pct);
        HWR_DATA  = (hwr_q.size() > 0) ? hwr_q[0] : '0;
        CHNL_TX_DATA_VALID = (tx_q.size() > 0) && (int'($urandom_range(0, 99)) < txv_pct);
        CHNL_TX_DATA = (tx_q.size() > 0) ? tx_q[0] : '0;
        HRD_READY = (hrd_stall == 0);
        #1;
        step_cnt++;
        if (HWR_VALID && HWR_READY) void'(hwr_q.pop_front());
        if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) begin
            rx_got.push_back(CHNL_RX_DATA);
            if (loopback) tx_q.push_back(CHNL_RX_DATA);
        end
        if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) void'(tx_q.pop_front());
        if (HRD_VALID && HRD_READY) hrd_got.push_back(HRD_DATA);
        if (HRD_VALID && !HRD_READY) begin
            stall_full++;
            if (CHNL_TX_DATA_REN) ren_viol++;
        end
        if (RX_DONE) rx_done_cnt++;
        if (TX_DONE) tx_done_cnt++;
        if (CHNL_TX_ACK) begin
            tx_ack_cnt++;
            if (tx_ack_step < 0) tx_ack_step = step_cnt;
        end
        if (CHNL_RX) begin
            rx_hi++;
            if (rx_rise_step < 0) rx_rise_step = step_cnt;
            if (!rx_seen) begin
                rx_seen = 1'b1;
                rx_hdr = {CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF};
            end else if (rx_hdr !== {CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF}) begin
                rx_unstable++;
            end
        end else begin
            rx_seen = 1'b0;
        end
        if (hrd_stall > 0) hrd_stall--;
        else if (stall_arm && hrd_got.size() == 1) begin
            hrd_stall = 5;
            stall_arm = 1'b0;
        end
    endtask

    function automatic logic any_out();
        return |{HWR_READY, HRD_DATA, HRD_VALID, RX_BUSY, RX_DONE, TX_DONE, TX_LEN_Q, CHNL_RX,
                 CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
                 CHNL_TX_ACK, CHNL_TX_DATA_REN};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        #1;
        n_tests++;
        if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: any output set = %b, want 0", any_out());
        end
        RST_N = 1'b1;
        clear_obs();
        step();
        step();
        n_tests++;
        if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL idle_outputs: any output set = %b, want 0", any_out());
        end
    endtask

    task automatic test_rx_basic();
        int nb;
        int start_step;
        logic [30:0] off;
        bit bad;
        clear_obs();
        ren_mode = 0; hwr_pct = 100;
        nb = (4 + W - 1) / W;
        load_hwr(nb + 1);
        off = 31'($urandom);
        START_LEN = 32'd4; START_OFF = off; START_LAST = 1'b1; START = 1'b1;
        start_step = step_cnt;
        for (int c = 0; c < 60 && rx_done_cnt == 0; c++) step();
        repeat (3) step();
        n_tests++;
        if (rx_rise_step !== start_step + 1) begin
            n_fail++;
            $display("FAIL rx_start_latency: CHNL_RX rose after %0d cycles, want 1",
                     rx_rise_step - start_step);
        end
        n_tests++;
        if (rx_hi !== nb + 2) begin
            n_fail++; $display("FAIL rx_high_cycles: got %0d, want %0d", rx_hi, nb + 2);
        end
        bad = (rx_got.size() != nb);
        for (int i = 0; i < rx_got.size() && i < nb; i++) if (rx_got[i] !== sent[i]) bad = 1'b1;
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL rx_basic_data: %0d beats received, want %0d in order",
                               rx_got.size(), nb);
        end
        n_tests++;
        if (rx_done_cnt !== 1) begin
            n_fail++; $display("FAIL rx_done_pulse: got %0d pulses, want 1", rx_done_cnt);
        end
        n_tests++;
        if (hwr_q.size() !== 1) begin
            n_fail++; $display("FAIL rx_overfetch: %0d host beats left, want 1", hwr_q.size());
        end
        n_tests++;
        if (rx_hdr !== {1'b1, 32'd4, off} || rx_unstable !== 0) begin
            n_fail++; $display("FAIL rx_header: got %h (changes %0d), want %h",
                               rx_hdr, rx_unstable, {1'b1, 32'd4, off});
        end
        n_tests++;
        if ({CHNL_RX, RX_BUSY} !== 2'b00) begin
            n_fail++; $display("FAIL rx_idle_after: CHNL_RX/RX_BUSY = %b, want 00",
                               {CHNL_RX, RX_BUSY});
        end
    endtask

    task automatic test_rx_len0();
        clear_obs();
        load_hwr(1);
        START_LEN = 32'd0; START_OFF = '0; START_LAST = 1'b0; START = 1'b1;
        for (int c = 0; c < 20 && rx_done_cnt == 0; c++) step();
        repeat (2) step();
        n_tests++;
        if (rx_done_cnt !== 1 || rx_got.size() !== 0 || hwr_q.size() !== 1 || rx_hi !== 1) begin
            n_fail++;
            $display("FAIL rx_len0: done=%0d beats=%0d left=%0d high=%0d, want 1 0 1 1",
                     rx_done_cnt, rx_got.size(), hwr_q.size(), rx_hi);
        end
    endtask

    task automatic test_rx_random();
        int len, nb;
        logic [30:0] off;
        logic last;
        bit bad, injected;
        for (int it = 0; it < 5; it++) begin
            clear_obs();
            len = (it == 0) ? 8 : int'($urandom_range(1, 11));
            ren_mode = (it == 0) ? 1 : 2;
            hwr_pct = 50;
            nb = (len + W - 1) / W;
            load_hwr(nb + 2);
            off = 31'($urandom);
            last = 1'($urandom_range(0, 1));
            START_LEN = 32'(len); START_OFF = off; START_LAST = last; START = 1'b1;
            injected = 1'b0;
            for (int c = 0; c < 400 && rx_done_cnt == 0; c++) begin
                step();
                if (!injected && rx_got.size() >= 1) begin
                    injected = 1'b1;
                    START_LEN = 32'(len + 3); START_OFF = ~off; START_LAST = ~last; START = 1'b1;
                end
            end
            repeat (2) step();
            bad = (rx_got.size() != nb) || (rx_got.size() * W - len >= W);
            for (int i = 0; i < rx_got.size() && i < nb; i++) if (rx_got[i] !== sent[i]) bad = 1'b1;
            n_tests++;
            if (bad || hwr_q.size() !== 2) begin
                n_fail++;
                $display("FAIL rx_random_data[%0d]: len %0d got %0d beats, left %0d, want %0d, 2",
                         it, len, rx_got.size(), hwr_q.size(), nb);
            end
            n_tests++;
            if (rx_done_cnt !== 1 || rx_unstable !== 0 || rx_hdr !== {last, 32'(len), off}) begin
                n_fail++;
                $display("FAIL rx_random_ctl[%0d]: done=%0d changes=%0d hdr=%h want 1 0 %h",
                         it, rx_done_cnt, rx_unstable, rx_hdr, {last, 32'(len), off});
            end
        end
        ren_mode = 0; hwr_pct = 100;
    endtask

    task automatic test_tx_basic();
        int raise_step;
        bit bad;
        clear_obs();
        txv_pct = 100;
        load_tx(4);
        CHNL_TX_LEN = 32'd5; CHNL_TX = 1'b1;
        raise_step = step_cnt;
        for (int c = 0; c < 60 && tx_done_cnt == 0; c++) step();
        repeat (6) step();
        n_tests++;
        if (tx_ack_step !== raise_step + 1 || tx_ack_cnt !== 1) begin
            n_fail++; $display("FAIL tx_ack: latency %0d count %0d, want 1 1",
                               tx_ack_step - raise_step, tx_ack_cnt);
        end
        bad = (hrd_got.size() != 3);
        for (int i = 0; i < hrd_got.size() && i < 3; i++) if (hrd_got[i] !== tx_sent[i]) bad = 1'b1;
        n_tests++;
        if (bad || tx_q.size() !== 1) begin
            n_fail++; $display("FAIL tx_basic_data: %0d beats out, %0d left, want 3 1",
                               hrd_got.size(), tx_q.size());
        end
        n_tests++;
        if (TX_LEN_Q !== 32'd5) begin
            n_fail++; $display("FAIL tx_len_q: got %0d, want 5", TX_LEN_Q);
        end
        n_tests++;
        if (tx_done_cnt !== 1 || CHNL_TX_DATA_REN !== 1'b0) begin
            n_fail++; $display("FAIL tx_done_hold: pulses %0d ren %b, want 1 0",
                               tx_done_cnt, CHNL_TX_DATA_REN);
        end
        CHNL_TX = 1'b0;
        repeat (2) step();
        tx_q.delete(); tx_sent.delete(); hrd_got.delete();
        load_tx(1);
        CHNL_TX_LEN = 32'd2; CHNL_TX = 1'b1;
        for (int c = 0; c < 60 && tx_done_cnt < 2; c++) step();
        CHNL_TX = 1'b0;
        repeat (2) step();
        n_tests++;
        if (tx_ack_cnt !== 2 || tx_done_cnt !== 2 || TX_LEN_Q !== 32'd2 ||
            hrd_got.size() !== 1) begin
            n_fail++; $display("FAIL tx_retrigger: acks %0d dones %0d len %0d beats %0d, want 2 2 2 1",
                               tx_ack_cnt, tx_done_cnt, TX_LEN_Q, hrd_got.size());
        end
    endtask

    task automatic test_tx_stall();
        bit bad;
        clear_obs();
        load_tx(3);
        stall_arm = 1'b1;
        CHNL_TX_LEN = 32'd6; CHNL_TX = 1'b1;
        for (int c = 0; c < 80 && tx_done_cnt == 0; c++) step();
        CHNL_TX = 1'b0;
        repeat (2) step();
        bad = (hrd_got.size() != 3);
        for (int i = 0; i < hrd_got.size() && i < 3; i++) if (hrd_got[i] !== tx_sent[i]) bad = 1'b1;
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL tx_stall_data: %0d beats out, want 3 in order", hrd_got.size());
        end
        n_tests++;
        if (ren_viol !== 0 || stall_full < 5) begin
            n_fail++; $display("FAIL tx_stall_ren: REN high while blocked %0d, blocked cycles %0d, want 0 >=5",
                               ren_viol, stall_full);
        end
        n_tests++;
        if (tx_done_cnt !== 1) begin
            n_fail++; $display("FAIL tx_stall_done: got %0d pulses, want 1", tx_done_cnt);
        end
    endtask

    task automatic test_loopback();
        bit bad;
        int nb;
        clear_obs();
        loopback = 1'b1;
        nb = (3 + W - 1) / W;
        load_hwr(nb + 1);
        START_LEN = 32'd3; START_OFF = 31'd7; START_LAST = 1'b1; START = 1'b1;
        CHNL_TX_LEN = 32'd3; CHNL_TX = 1'b1;
        for (int c = 0; c < 200 && (rx_done_cnt == 0 || tx_done_cnt == 0); c++) step();
        CHNL_TX = 1'b0;
        repeat (3) step();
        bad = (hrd_got.size() != nb);
        for (int i = 0; i < hrd_got.size() && i < nb; i++) if (hrd_got[i] !== sent[i]) bad = 1'b1;
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL loopback_data: %0d beats to host, want %0d equal to source",
                               hrd_got.size(), nb);
        end
        n_tests++;
        if (rx_done_cnt !== 1 || tx_done_cnt !== 1) begin
            n_fail++; $display("FAIL loopback_done: rx %0d tx %0d, want 1 1", rx_done_cnt, tx_done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        clear_obs();
        load_hwr(5);
        START_LEN = 32'd8; START_OFF = 31'd3; START_LAST = 1'b0; START = 1'b1;
        for (int c = 0; c < 60 && rx_got.size() < 2; c++) step();
        n_tests++;
        if (rx_got.size() !== 2) begin
            n_fail++; $display("FAIL reset_mid_setup: %0d beats before reset, want 2", rx_got.size());
        end
        #2 RST_N = 1'b0;
        #1;
        n_tests++;
        if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_async: any output set = %b, want 0", any_out());
        end
        repeat (3) step();
        RST_N = 1'b1;
        repeat (3) step();
        n_tests++;
        if (rx_done_cnt !== 0 || RX_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_abort: done %0d busy %b, want 0 0", rx_done_cnt, RX_BUSY);
        end
        clear_obs();
        load_hwr(2);
        START_LEN = 32'd2; START_OFF = 31'd1; START_LAST = 1'b1; START = 1'b1;
        for (int c = 0; c < 60 && rx_done_cnt == 0; c++) step();
        repeat (2) step();
        bad = (rx_got.size() != 1) || (rx_got.size() == 1 && rx_got[0] !== sent[0]);
        n_tests++;
        if (bad || rx_done_cnt !== 1 || hwr_q.size() !== 1) begin
            n_fail++; $display("FAIL reset_recover: beats %0d done %0d left %0d, want 1 1 1",
                               rx_got.size(), rx_done_cnt, hwr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_len0();
        test_rx_random();
        test_tx_basic();
        test_tx_stall();
        test_loopback();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
